spi_cmd_decoder: RTL

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 46 ++++
 rtl/spi_cmd_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: header tags, FSM states, command record.
package spi_cmd_decoder_pkg;

    localparam logic [2:0] TAG_CONF  = 3'b111;
    localparam logic [2:0] TAG_POS   = 3'b110;
    localparam int         COORD_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONF_DATA = 2'd1,
        ST_POS_X     = 2'd2,
        ST_POS_Y     = 2'd3
    } state_e;

    // Coordinates sized for the widest build; the top keeps only COORD_W bits.
    typedef struct packed {
        logic                 conf;
        logic [1:0]           ch;
        logic                 brush;
        logic [2:0]           color;
        logic [COORD_MAX-1:0] x;
        logic [COORD_MAX-1:0] y;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO, head read straight from registered storage.
// Latency: a push is visible at the head the cycle after. Backpressure: push into a full FIFO is ignored, even with a same-cycle pop.
// Full/empty come from pointers carrying one extra wrap bit.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI byte packets into config/position commands queued in a FIFO.
// Latency: cmdValid rises 1 clk after the final data byte. Backpressure: cmdReady pops the head; a full FIFO drops the new command and pulses overflow.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int COORD_W    = 8,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               byteValid,
    input  logic [7:0]         byteIn,
    input  logic               frameEnd,
    output logic               cmdValid,
    input  logic               cmdReady,
    output logic               cmdConf,
    output logic [1:0]         cmdCh,
    output logic               cmdBrush,
    output logic [2:0]         cmdColor,
    output logic [COORD_W-1:0] cmdX,
    output logic [COORD_W-1:0] cmdY,
    output logic               badHdr,
    output logic               overflow
);

    localparam int                   NB       = (COORD_W + 7) / 8;
    localparam int                   FW       = 7 + 2 * COORD_W;
    localparam logic [1:0]           CNT_LAST = 2'(NB - 1);
    localparam logic [2:0]           NCH      = 3'(NUM_CH);
    localparam logic [COORD_MAX-1:0] CMASK    = COORD_MAX'((32'd1 << COORD_W) - 32'd1);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    cmd_t            cmd_q, cmd_d;
    logic            badhdr_q, badhdr_d;
    logic            ovf_q;
    logic            push, fifo_full, fifo_empty;
    logic            ch_ok, is_conf_hdr, is_pos_hdr;
    logic [FW-1:0]   push_dat, head;

    assign ch_ok       = ({1'b0, byteIn[1:0]} < NCH);
    assign is_conf_hdr = (byteIn[7:5] == TAG_CONF) && (byteIn[4:2] == 3'b000);
    assign is_pos_hdr  = (byteIn[7:5] == TAG_POS)  && (byteIn[4:2] == 3'b000);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        push     = 1'b0;
        badhdr_d = 1'b0;
        if (byteValid) begin
            case (state_q)
                ST_IDLE: begin
                    cmd_d = '0;
                    cnt_d = '0;
                    if (is_conf_hdr && ch_ok) begin
                        cmd_d.conf = 1'b1;
                        cmd_d.ch   = byteIn[1:0];
                        state_d    = ST_CONF_DATA;
                    end else if (is_pos_hdr && ch_ok) begin
                        cmd_d.ch   = byteIn[1:0];
                        state_d    = ST_POS_X;
                    end else begin
                        badhdr_d   = 1'b1;
                    end
                end
                ST_CONF_DATA: begin
                    cmd_d.brush = byteIn[4];
                    cmd_d.color = byteIn[2:0];
                    push        = 1'b1;
                    state_d     = ST_IDLE;
                end
                // Shift in MSB byte first; masking drops unused high bits of the first byte.
                ST_POS_X: begin
                    cmd_d.x = {cmd_q.x[COORD_MAX-9:0], byteIn} & CMASK;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_POS_Y;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
                default: begin
                    cmd_d.y = {cmd_q.y[COORD_MAX-9:0], byteIn} & CMASK;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
            endcase
        end
        // The coinciding byte has already been handled above, so a completing byte still pushes.
        if (frameEnd) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            badhdr_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            badhdr_q <= badhdr_d;
            ovf_q    <= push && fifo_full;
        end
    end

    assign push_dat = {cmd_d.conf, cmd_d.ch, cmd_d.brush, cmd_d.color,
                       cmd_d.x[COORD_W-1:0], cmd_d.y[COORD_W-1:0]};

    cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (cmdValid && cmdReady),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head)
    );

    assign cmdValid = !fifo_empty;
    assign {cmdConf, cmdCh, cmdBrush, cmdColor, cmdX, cmdY} = head;
    assign badHdr   = badhdr_q;
    assign overflow = ovf_q;

endmodule
